// File: rtl/gps_synth_pkg.sv
// ============================================================================
//  Module      : gps_synth_pkg
//  Description : Shared constants, sample/product types and the quarter-wave
//                cosine table used by the Doppler wipe-off datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gps_synth_pkg;

    localparam int c_LUT_DEPTH = 64;
    localparam int c_LUT_IDX_W = 6;
    localparam int c_SAMPLE_W  = 6;
    localparam int c_PROD_W    = 13;
    localparam int c_LUT_AMP   = 31;

    typedef logic signed [c_SAMPLE_W-1:0] sample_t;
    typedef logic signed [c_PROD_W-1:0]   prod_t;

    // round(31*cos(2*pi*a/64)) for a = 0..16 (first quadrant)
    function automatic sample_t quarter_cos(input logic [c_LUT_IDX_W-1:0] a);
        sample_t v;
        v = '0;
        case (a)
            6'd0:    v = sample_t'(c_LUT_AMP);
            6'd1:    v = 6'sd31;
            6'd2:    v = 6'sd30;
            6'd3:    v = 6'sd30;
            6'd4:    v = 6'sd29;
            6'd5:    v = 6'sd27;
            6'd6:    v = 6'sd26;
            6'd7:    v = 6'sd24;
            6'd8:    v = 6'sd22;
            6'd9:    v = 6'sd20;
            6'd10:   v = 6'sd17;
            6'd11:   v = 6'sd15;
            6'd12:   v = 6'sd12;
            6'd13:   v = 6'sd9;
            6'd14:   v = 6'sd6;
            6'd15:   v = 6'sd3;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Full-circle cosine built from the first quadrant by symmetry
    function automatic sample_t lut_cos(input logic [c_LUT_IDX_W-1:0] m);
        sample_t v;
        v = '0;
        if (m <= 6'd16)
            v = quarter_cos(m);
        else if (m <= 6'd32)
            v = -quarter_cos(6'd32 - m);
        else if (m <= 6'd48)
            v = -quarter_cos(m - 6'd32);
        else
            v = quarter_cos(6'd0 - m);
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wipeoff_trig_lut.sv
// ============================================================================
//  Module      : wipeoff_trig_lut
//  Description : Registered 64-entry cos/sin table, one-cycle latency.
//                sin(m) is read as cos(m - 16), a quarter turn back.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wipeoff_trig_lut
    import gps_synth_pkg::*;
(
    input  logic                   clk,
    input  logic [c_LUT_IDX_W-1:0] i_idx,
    output sample_t                o_cos,
    output sample_t                o_sin
);

    logic [c_LUT_IDX_W-1:0] w_sin_idx;
    sample_t                r_cos;
    sample_t                r_sin;

    assign w_sin_idx = i_idx - c_LUT_IDX_W'(c_LUT_DEPTH / 4);

    // Table read registered; contents are pure data so no reset is needed
    always_ff @(posedge clk) begin
        r_cos <= lut_cos(i_idx);
        r_sin <= lut_cos(w_sin_idx);
    end

    assign o_cos = r_cos;
    assign o_sin = r_sin;

endmodule

`default_nettype wire

// File: rtl/doppler_wipeoff_accum.sv
// ============================================================================
//  Module      : doppler_wipeoff_accum
//  Description : Carrier wipe-off (multiply by e^-j*theta from an NCO) and
//                integrate-and-dump of 6-bit I/Q samples. Three-stage pipe:
//                LUT read, complex multiply, accumulate/dump.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module doppler_wipeoff_accum
    import gps_synth_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ACC_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dv_in,
    input  logic signed [5:0]     i_in,
    input  logic signed [5:0]     q_in,
    input  logic [PHASE_W-1:0]    freq,
    input  logic [15:0]           dump_len,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic signed [ACC_W-1:0] i_acc,
    output logic signed [ACC_W-1:0] q_acc,
    output logic                  overrun
);

    // ---------------- stage 0: phase / sample count ----------------
    logic [PHASE_W-1:0]     r_phase;
    logic [15:0]            r_cnt;
    logic [15:0]            r_len;
    logic [15:0]            w_len_in;
    logic [15:0]            w_len_cur;
    logic [15:0]            w_cnt_cur;
    logic [PHASE_W-1:0]     w_phase_cur;
    logic                   w_last;
    logic [c_LUT_IDX_W-1:0] w_idx;

    // A start in the same cycle as dv_in makes that sample k=0 of the new block
    assign w_len_in    = (dump_len == 16'd0) ? 16'd1 : dump_len;
    assign w_len_cur   = start ? w_len_in : r_len;
    assign w_cnt_cur   = start ? 16'd0 : r_cnt;
    assign w_phase_cur = start ? '0 : r_phase;
    assign w_last      = (w_cnt_cur == (w_len_cur - 16'd1));
    assign w_idx       = w_phase_cur[PHASE_W-1 -: c_LUT_IDX_W];

    // Advance phase and sample count per accepted sample; relatch block length at dumps
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase <= '0;
            r_cnt   <= '0;
            r_len   <= w_len_in;
        end else if (dv_in) begin
            r_phase <= w_phase_cur + freq;
            if (w_last) begin
                r_cnt <= '0;
                r_len <= w_len_in;
            end else begin
                r_cnt <= w_cnt_cur + 16'd1;
                r_len <= w_len_cur;
            end
        end else if (start) begin
            r_phase <= '0;
            r_cnt   <= '0;
            r_len   <= w_len_in;
        end
    end

    // ---------------- stage 1: LUT read ----------------
    logic    r_s1_vld;
    logic    r_s1_last;
    sample_t r_s1_i;
    sample_t r_s1_q;
    sample_t w_cos;
    sample_t w_sin;

    wipeoff_trig_lut u_lut (
        .clk   (clk),
        .i_idx (w_idx),
        .o_cos (w_cos),
        .o_sin (w_sin)
    );

    // Carry the sample alongside the table read; start leaves only a coincident new sample
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_i    <= '0;
            r_s1_q    <= '0;
        end else begin
            r_s1_vld  <= dv_in;
            r_s1_last <= dv_in & w_last;
            r_s1_i    <= i_in;
            r_s1_q    <= q_in;
        end
    end

    // ---------------- stage 2: complex multiply ----------------
    logic  r_s2_vld;
    logic  r_s2_last;
    prod_t r_s2_ip;
    prod_t r_s2_qp;
    prod_t w_ip;
    prod_t w_qp;

    // (I + jQ) * (C - jS)
    assign w_ip = prod_t'(r_s1_i) * prod_t'(w_cos) + prod_t'(r_s1_q) * prod_t'(w_sin);
    assign w_qp = prod_t'(r_s1_q) * prod_t'(w_cos) - prod_t'(r_s1_i) * prod_t'(w_sin);

    // Register mixed products; a start drops whatever was in the LUT stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_ip   <= '0;
            r_s2_qp   <= '0;
        end else begin
            r_s2_vld  <= r_s1_vld & ~start;
            r_s2_last <= r_s1_last;
            r_s2_ip   <= w_ip;
            r_s2_qp   <= w_qp;
        end
    end

    // ---------------- stage 3: integrate and dump ----------------
    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic signed [ACC_W-1:0] w_sum_i;
    logic signed [ACC_W-1:0] w_sum_q;
    logic                    w_new;

    assign w_sum_i = r_acc_i + ACC_W'(r_s2_ip);
    assign w_sum_q = r_acc_q + ACC_W'(r_s2_qp);
    assign w_new   = r_s2_vld & r_s2_last & ~start;

    // Integrators wrap on overflow and restart at zero after the dump sample
    always_ff @(posedge clk) begin
        if (!reset || start) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (r_s2_vld) begin
            if (r_s2_last) begin
                r_acc_i <= '0;
                r_acc_q <= '0;
            end else begin
                r_acc_i <= w_sum_i;
                r_acc_q <= w_sum_q;
            end
        end
    end

    // ---------------- output register / handshake ----------------
    logic                    r_out_valid;
    logic                    r_overrun;
    logic signed [ACC_W-1:0] r_out_i;
    logic signed [ACC_W-1:0] r_out_q;

    // Load a finished block unless an unaccepted result is still held
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
        end else begin
            r_overrun <= 1'b0;
            if (w_new) begin
                if (r_out_valid && !out_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_i     <= w_sum_i;
                    r_out_q     <= w_sum_q;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign i_acc     = r_out_i;
    assign q_acc     = r_out_q;

endmodule

`default_nettype wire

// File: tb/tb_doppler_wipeoff_accum.sv
// ============================================================================
//  Module      : tb_doppler_wipeoff_accum
//  Description : Self-checking bench for doppler_wipeoff_accum with a
//                trig-based reference model of the integrate-and-dump.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_doppler_wipeoff_accum;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              dv_in;
    logic signed [5:0] i_in;
    logic signed [5:0] q_in;
    logic [31:0]       freq;
    logic [15:0]       dump_len;
    logic              out_ready;
    logic              out_valid;
    logic signed [31:0] i_acc;
    logic signed [31:0] q_acc;
    logic              overrun;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc_n = 0;

    typedef struct {
        longint stamp;
        int     ei;
        int     eq;
    } exp_t;

    exp_t   exp_q[$];
    longint m_k;
    longint m_f;
    int     m_cnt;
    int     m_len;
    int     m_ai;
    int     m_aq;

    always #5 clk = ~clk;

    doppler_wipeoff_accum #(.PHASE_W(32), .ACC_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dv_in     (dv_in),
        .i_in      (i_in),
        .q_in      (q_in),
        .freq      (freq),
        .dump_len  (dump_len),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .i_acc     (i_acc),
        .q_acc     (q_acc),
        .overrun   (overrun)
    );

    // ---------------- reference model ----------------
    function automatic int ref_c(int m);
        real a;
        a = 2.0 * 3.141592653589793 * real'(m) / 64.0;
        return int'($floor(31.0 * $cos(a) + 0.5));
    endfunction

    function automatic int ref_s(int m);
        real a;
        a = 2.0 * 3.141592653589793 * real'(m) / 64.0;
        return int'($floor(31.0 * $sin(a) + 0.5));
    endfunction

    function automatic int idx_of(longint k, longint f);
        longint unsigned ph;
        ph = (longint'(k) * longint'(f)) % 64'h1_0000_0000;
        return int'(ph >> 26);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic model_reset(int dl, longint f);
        exp_q.delete();
        m_k = 0; m_cnt = 0; m_ai = 0; m_aq = 0;
        m_len = (dl == 0) ? 1 : dl;
        m_f = f;
    endtask

    // Drive one cycle and advance the model; blocks whose last sample was
    // accepted within two edges before a start never reach the output.
    task automatic model_drive(bit st, bit dv, int i, int q, int dl, longint f);
        longint t;
        int     m;
        t = cyc_n + 1;
        if (st) begin
            while (exp_q.size() > 0 && exp_q[$].stamp >= t - 2) void'(exp_q.pop_back());
            m_k = 0; m_cnt = 0; m_ai = 0; m_aq = 0;
            m_len = (dl == 0) ? 1 : dl;
            m_f = f;
        end
        if (dv) begin
            m = idx_of(m_k, m_f);
            m_ai += i * ref_c(m) + q * ref_s(m);
            m_aq += q * ref_c(m) - i * ref_s(m);
            m_k++;
            m_cnt++;
            if (m_cnt == m_len) begin
                exp_q.push_back('{stamp: t, ei: m_ai, eq: m_aq});
                m_ai = 0; m_aq = 0; m_cnt = 0;
                m_len = (dl == 0) ? 1 : dl;
            end
        end
        start    = st;
        dv_in    = dv;
        i_in     = 6'(i);
        q_in     = 6'(q);
        dump_len = 16'(dl);
        freq     = 32'(m_f);
        tick();
    endtask

    task automatic idle();
        start = 1'b0;
        dv_in = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; idle(); out_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({out_valid, overrun} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags: got valid=%0b ovr=%0b want 0 0", out_valid, overrun);
        end
        n_cmp++;
        if (i_acc !== 32'sd0 || q_acc !== 32'sd0) begin
            n_bad++; $display("FAIL reset_acc: got %0d,%0d want 0,0", i_acc, q_acc);
        end
        reset = 1'b1;
        tick();
        model_reset(1, 0);
    endtask

    task automatic test_const_block(string name, longint f, int dl, int i, int q, int nblk);
        int  len;
        bit  ev;
        out_ready = 1'b1;
        len = (dl == 0) ? 1 : dl;
        for (int s = 0; s < nblk * len + 4; s++) begin
            if (s < nblk * len) model_drive(s == 0, 1'b1, i, q, dl, f);
            else                model_drive(1'b0, 1'b0, 0, 0, dl, f);
            ev = (exp_q.size() > 0 && exp_q[0].stamp == cyc_n - 2);
            n_cmp++;
            if ({out_valid, overrun} !== {ev, 1'b0}) begin
                n_bad++; $display("FAIL %s_valid cyc %0d: got valid=%0b ovr=%0b want %0b 0", name, s, out_valid, overrun, ev);
            end
            if (ev) begin
                n_cmp++;
                if (i_acc !== exp_q[0].ei || q_acc !== exp_q[0].eq) begin
                    n_bad++; $display("FAIL %s_data: got %0d,%0d want %0d,%0d", name, i_acc, q_acc, exp_q[0].ei, exp_q[0].eq);
                end
                void'(exp_q.pop_front());
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL %s_missing: got %0d results outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_overrun();
        int e;
        e = ref_c(0);
        out_ready = 1'b0; freq = 32'd0; dump_len = 16'd1;
        start = 1'b1; dv_in = 1'b1; i_in = 6'sd1; q_in = 6'sd0;
        tick();
        start = 1'b0;
        tick();
        idle();
        tick();
        n_cmp++;
        if ({out_valid, overrun} !== 2'b10 || i_acc !== e || q_acc !== 0) begin
            n_bad++; $display("FAIL ovr_first: got v=%0b o=%0b %0d,%0d want 1 0 %0d,0", out_valid, overrun, i_acc, q_acc, e);
        end
        tick();
        n_cmp++;
        if ({out_valid, overrun} !== 2'b11 || i_acc !== e || q_acc !== 0) begin
            n_bad++; $display("FAIL ovr_pulse: got v=%0b o=%0b %0d,%0d want 1 1 %0d,0", out_valid, overrun, i_acc, q_acc, e);
        end
        tick();
        n_cmp++;
        if ({out_valid, overrun} !== 2'b10 || i_acc !== e) begin
            n_bad++; $display("FAIL ovr_hold: got v=%0b o=%0b %0d want 1 0 %0d", out_valid, overrun, i_acc, e);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, overrun} !== 2'b00) begin
            n_bad++; $display("FAIL ovr_drain: got v=%0b o=%0b want 0 0", out_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        int a_i, a_q, b_i, b_q, ea_i, ea_q, eb_i, eb_q;
        a_i = int'($urandom_range(0, 63)) - 32; a_q = int'($urandom_range(0, 63)) - 32;
        b_i = int'($urandom_range(0, 63)) - 32; b_q = int'($urandom_range(0, 63)) - 32;
        ea_i = a_i * ref_c(0) + a_q * ref_s(0); ea_q = a_q * ref_c(0) - a_i * ref_s(0);
        eb_i = b_i * ref_c(0) + b_q * ref_s(0); eb_q = b_q * ref_c(0) - b_i * ref_s(0);
        out_ready = 1'b1; freq = 32'd0; dump_len = 16'd1;
        start = 1'b1; dv_in = 1'b1; i_in = 6'(a_i); q_in = 6'(a_q);
        tick();
        start = 1'b0; i_in = 6'(b_i); q_in = 6'(b_q);
        tick();
        idle();
        tick();
        n_cmp++;
        if ({out_valid, overrun} !== 2'b10 || i_acc !== ea_i || q_acc !== ea_q) begin
            n_bad++; $display("FAIL b2b_first: got v=%0b o=%0b %0d,%0d want 1 0 %0d,%0d", out_valid, overrun, i_acc, q_acc, ea_i, ea_q);
        end
        tick();
        n_cmp++;
        if ({out_valid, overrun} !== 2'b10 || i_acc !== eb_i || q_acc !== eb_q) begin
            n_bad++; $display("FAIL b2b_second: got v=%0b o=%0b %0d,%0d want 1 0 %0d,%0d", out_valid, overrun, i_acc, q_acc, eb_i, eb_q);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_drop: got valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit ev;
        out_ready = 1'b1; freq = 32'd0; dump_len = 16'd4;
        start = 1'b1; dv_in = 1'b1; i_in = 6'sd31; q_in = 6'sd0;
        tick();
        start = 1'b0;
        tick();
        idle(); reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({out_valid, overrun} !== 2'b00 || i_acc !== 0 || q_acc !== 0) begin
                n_bad++; $display("FAIL rstmid_zero: got v=%0b o=%0b %0d,%0d want 0 0 0,0", out_valid, overrun, i_acc, q_acc);
            end
        end
        reset = 1'b1;
        tick();
        model_reset(4, 0);
        for (int s = 0; s < 8; s++) begin
            if (s < 4) model_drive(1'b0, 1'b1, 31, 0, 4, 0);
            else       model_drive(1'b0, 1'b0, 0, 0, 4, 0);
            ev = (exp_q.size() > 0 && exp_q[0].stamp == cyc_n - 2);
            n_cmp++;
            if (out_valid !== ev) begin
                n_bad++; $display("FAIL rstmid_valid cyc %0d: got %0b want %0b", s, out_valid, ev);
            end
            if (ev) begin
                n_cmp++;
                if (i_acc !== exp_q[0].ei || q_acc !== exp_q[0].eq) begin
                    n_bad++; $display("FAIL rstmid_data: got %0d,%0d want %0d,%0d", i_acc, q_acc, exp_q[0].ei, exp_q[0].eq);
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_random();
        bit     ev, st, dv;
        int     dl;
        longint f;
        out_ready = 1'b1;
        f = longint'($urandom());
        for (int s = 0; s < 600; s++) begin
            st = (s == 0) || ($urandom_range(0, 24) == 0);
            if (st) f = longint'($urandom());
            dv = (s < 596) && ($urandom_range(0, 3) != 0);
            dl = int'($urandom_range(0, 6));
            model_drive(st, dv, int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32, dl, f);
            ev = (exp_q.size() > 0 && exp_q[0].stamp == cyc_n - 2);
            n_cmp++;
            if ({out_valid, overrun} !== {ev, 1'b0}) begin
                n_bad++; $display("FAIL rand_valid cyc %0d: got valid=%0b ovr=%0b want %0b 0", s, out_valid, overrun, ev);
            end
            if (ev) begin
                n_cmp++;
                if (i_acc !== exp_q[0].ei || q_acc !== exp_q[0].eq) begin
                    n_bad++; $display("FAIL rand_data cyc %0d: got %0d,%0d want %0d,%0d", s, i_acc, q_acc, exp_q[0].ei, exp_q[0].eq);
                end
                void'(exp_q.pop_front());
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL rand_missing: got %0d results outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; dv_in = 1'b0; i_in = '0; q_in = '0;
        freq = '0; dump_len = 16'd1; out_ready = 1'b1;
        test_reset();
        test_const_block("dc_i",    0,            4, 31,  0, 1);
        test_const_block("dc_q",    0,            2,  0, 10, 1);
        test_const_block("quarter", 64'h4000_0000, 4, 31,  0, 2);
        test_const_block("dl0",     0,            0, -7, 12, 3);
        test_const_block("wrap",    64'h1234_5678, 5, -32, -32, 3);
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/doppler_wipeoff_accum.md
DOPPLER_WIPEOFF_ACCUM -- requirements
Module: doppler_wipeoff_accum

Interface
REQ-001 SHALL have parameter PHASE_W, default 32, meaning phase accumulator width.
REQ-002 SHALL have parameter ACC_W, default 32, meaning width of each I/Q integrator.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; restarts phase, sample count and integrators.
REQ-006 SHALL have port dv_in  input  1  input sample valid.
REQ-007 SHALL have port i_in / q_in  input  6 each  signed two's-complement received sample.
REQ-008 SHALL have port freq  input  PHASE_W  unsigned phase increment per accepted sample.
REQ-009 SHALL have port dump_len  input  16  samples per integration; 0 treated as 1.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_valid  output  1  result held in output register.
REQ-012 SHALL have port i_acc / q_acc  output  ACC_W each  signed integrated result.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse, result dropped.

Function
REQ-014 SHALL number accepted samples k = 0,1,... from last start/reset; sample k uses phase = k*freq mod 2^PHASE_W, index m = phase[PHASE_W-1 -: 6].
REQ-015 SHALL use LUT values C(m)=round(31*cos(2*pi*m/64)), S(m)=round(31*sin(2*pi*m/64)), 6-bit signed.
REQ-016 SHALL mix by e^(-j*theta): I' = I*C + Q*S, Q' = Q*C - I*S, full 13-bit signed precision.
REQ-017 SHALL sign-extend I'/Q' to ACC_W and add to integrators; wrap-around on overflow, no saturation.
REQ-018 SHALL latch dump_len at start/reset and at each dump; changes mid-block take effect next block.
REQ-019 SHALL, on the dump_len-th sample, load integrator sum including that sample into the output register and restart integrators at 0 for the next sample; phase is NOT reset at a dump.
REQ-020 SHALL assert out_valid exactly 3 cycles after the cycle the final sample's dv_in is accepted (pipeline: LUT read, multiply, accumulate).
REQ-021 SHALL hold out_valid, i_acc, q_acc stable until out_valid and out_ready both high; out_valid then drops the next cycle unless a new result loads.
REQ-022 SHALL, when a new result arrives while out_valid=1 and out_ready=0, keep the old result, discard the new one, and pulse overrun for one cycle.
REQ-023 SHALL, when a new result arrives in the same cycle out_valid=1 and out_ready=1, load the new result (out_valid stays 1, no overrun).
REQ-024 SHALL, on start, flush in-flight pipeline samples, zero phase/count/integrators; output register and out_valid unaffected.
REQ-025 SHALL treat dv_in coincident with start as sample k=0 of the new block.
REQ-026 SHALL accept samples every cycle with no stall; dv_in gaps just pause the pipeline count.

Reset
REQ-027 SHALL, with reset low at a clock edge, set phase, count, integrators, pipeline valids, out_valid, overrun to 0 and i_acc/q_acc to 0; dump_len latched fresh.
REQ-028 SHALL, on reset mid-block, discard the partial block and all in-flight samples.

Structure
REQ-029 SHALL place LUT depth (64), sample width (6), product width (13) and the LUT amplitude (31) in shared package gps_synth_pkg.
REQ-030 SHALL implement the registered cos/sin table as one sub-module wipeoff_trig_lut (index in, C and S out, one-cycle latency).

Verification
REQ-031 freq=0, I=31,Q=0, dump_len=4, 4 back-to-back samples -> i_acc=3844, q_acc=0, out_valid 3 cycles after 4th sample.
REQ-032 freq=0, I=0,Q=10, dump_len=2 -> i_acc=0, q_acc=620.
REQ-033 freq=2^30, I=31,Q=0, dump_len=4 -> indices 0,16,32,48; i_acc=0, q_acc=0; second block identical.
REQ-034 dump_len=1, out_ready=0, two samples I=1,Q=0,freq=0 -> first result (31,0) held, overrun pulses once, second dropped; out_ready=1 then out_valid drops.
REQ-035 out_valid=1, out_ready=1 in the same cycle a new result arrives -> new result visible next cycle, out_valid stays 1, overrun=0.
REQ-036 reset low after 2 of 4 samples, then 4 new samples I=31,Q=0,freq=0 -> outputs 0 during reset, next result 3844, 0.
